// File: rtl/toy_bus_age_arb_n.sv
// Oldest-first (age-matrix) N:1 arbiter for the toy bus ack/response channel, with packet lock.
// Latency: 0 cycles when FWD=0 (combinational mux); 1 cycle when FWD=1 (2-entry skid buffer).
// Backpressure: FWD=0 passes out_rdy straight to the granted in_rdy; FWD=1 accepts while the buffer is not full.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_vld / in_rdy           per-input handshake, bit i = input i
//   in_opcode .. in_last      per-input payload, field i = [i*W +: W]
//   out_vld / out_rdy         single downstream handshake
//   out_opcode .. out_last    payload of the granted (or buffered) beat
//   grant_oh                  current one-hot grant; lock_active = packet lock held
module toy_bus_age_arb_n #(
    parameter int NUM_IN  = 4,
    parameter int DATA_W  = 256,
    parameter int SB_W    = 10,
    parameter int ID_W    = 4,
    parameter int LOCK_EN = 1,
    parameter int FWD     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_vld,
    output logic [NUM_IN-1:0]        in_rdy,
    input  logic [NUM_IN-1:0]        in_opcode,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN*SB_W-1:0]   in_sideband,
    input  logic [NUM_IN*ID_W-1:0]   in_src_id,
    input  logic [NUM_IN*ID_W-1:0]   in_tgt_id,
    input  logic [NUM_IN-1:0]        in_last,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_opcode,
    output logic [DATA_W-1:0]        out_data,
    output logic [SB_W-1:0]          out_sideband,
    output logic [ID_W-1:0]          out_src_id,
    output logic [ID_W-1:0]          out_tgt_id,
    output logic                     out_last,
    output logic [NUM_IN-1:0]        grant_oh,
    output logic                     lock_active
);

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
        logic              last;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // age[i][j] = 1 : input j is older than input i. Diagonal is always 0.
    logic [NUM_IN-1:0] age [NUM_IN];

    logic [NUM_IN-1:0] sel;
    logic [NUM_IN-1:0] acc;
    logic [NUM_IN-1:0] lock_oh;
    logic              lock_q;
    logic              space;
    logic              acc_any;
    logic              acc_last;
    logic              upd;

    logic [BEAT_W-1:0] in_beat [NUM_IN];
    logic [BEAT_W-1:0] mux_beat;
    beat_t             out_beat;

    // ------------------------------------------------------------------
    // Payload slicing and AND-OR mux of the granted input
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_beat[i] = {in_opcode[i],
                          in_data[i*DATA_W +: DATA_W],
                          in_sideband[i*SB_W +: SB_W],
                          in_src_id[i*ID_W +: ID_W],
                          in_tgt_id[i*ID_W +: ID_W],
                          in_last[i]};
        end
    end

    always_comb begin
        mux_beat = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            mux_beat = mux_beat | (in_beat[i] & {BEAT_W{grant_oh[i]}});
        end
    end

    // ------------------------------------------------------------------
    // Oldest valid requester: valid and no older valid requester exists.
    // The matrix is a strict total order, so at most one bit is set.
    // ------------------------------------------------------------------
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel[i] = in_vld[i] & ~(|(age[i] & in_vld));
        end
    end

    // Grant is a function of valids and lock state only; readiness never
    // feeds back into the choice, which keeps the rdy path shallow.
    assign grant_oh    = lock_q ? lock_oh : sel;
    assign lock_active = lock_q;
    assign in_rdy      = grant_oh & {NUM_IN{space}};

    assign acc      = in_vld & in_rdy;
    assign acc_any  = |acc;
    assign acc_last = |(acc & in_last);

    // With locking, a packet ages its source only once it has completed.
    assign upd = acc_any & ((LOCK_EN == 0) | acc_last);

    // ------------------------------------------------------------------
    // Age matrix: the served input becomes youngest, the relative order of
    // all other inputs is untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    age[i][j] <= (j < i);
                end
            end
        end else if (upd) begin
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    if (acc[i]) begin
                        age[i][j] <= (j != i);
                    end else if (acc[j]) begin
                        age[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet lock: a non-last beat pins the grant to its source until that
    // source's last beat is accepted. Valid gaps from the owner keep the lock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= 1'b0;
            lock_oh <= '0;
        end else if ((LOCK_EN != 0) && acc_any) begin
            if (!acc_last) begin
                lock_q  <= 1'b1;
                lock_oh <= acc;
            end else begin
                lock_q  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (FWD != 0) begin : g_fwd
            // Two-entry circular skid buffer. in_rdy depends only on the
            // occupancy register, so out_rdy never reaches in_rdy.
            logic [BEAT_W-1:0] mem [2];
            logic              wr_ptr;
            logic              rd_ptr;
            logic [1:0]        cnt;
            logic              push;
            logic              pop;

            assign space = (cnt != 2'd2);
            assign push  = acc_any;
            assign pop   = (cnt != 2'd0) & out_rdy;

            always_ff @(posedge clk) begin
                if (rst) begin
                    mem[0] <= '0;
                    mem[1] <= '0;
                    wr_ptr <= 1'b0;
                    rd_ptr <= 1'b0;
                    cnt    <= 2'd0;
                end else begin
                    if (push) begin
                        mem[wr_ptr] <= mux_beat;
                        wr_ptr      <= ~wr_ptr;
                    end
                    if (pop) begin
                        rd_ptr <= ~rd_ptr;
                    end
                    if (push && !pop) begin
                        cnt <= cnt + 2'd1;
                    end else if (pop && !push) begin
                        cnt <= cnt - 2'd1;
                    end
                end
            end

            assign out_vld  = (cnt != 2'd0);
            assign out_beat = mem[rd_ptr];
        end else begin : g_comb
            assign space    = out_rdy;
            assign out_vld  = |(in_vld & grant_oh);
            assign out_beat = mux_beat;
        end
    endgenerate

    assign out_opcode   = out_beat.opcode;
    assign out_data     = out_beat.data;
    assign out_sideband = out_beat.sideband;
    assign out_src_id   = out_beat.src_id;
    assign out_tgt_id   = out_beat.tgt_id;
    assign out_last     = out_beat.last;

endmodule
